// File: rtl/config_chain_loader.sv
// Transmit end of the tile configuration shift chain: clears the chain, serialises
// host words into it LSB first, then recirculates it once to check a load-time CRC.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 36,
  parameter int WORD_WIDTH   = 16,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_enable,
  output logic                  config_nreset,
  input  logic                  config_out,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_error,
  output logic [15:0]           crc_value
);

  localparam int BCW = $clog2(CHAIN_LENGTH + 1);
  localparam int WCW = $clog2(WORD_WIDTH + 1);
  localparam int CCW = $clog2(CLEAR_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LENGTH - 1);
  localparam logic [WCW-1:0] LAST_WBIT = WCW'(WORD_WIDTH - 1);
  localparam logic [CCW-1:0] LAST_CLR  = CCW'(CLEAR_CYCLES - 1);
  localparam logic [15:0]    CRC_INIT  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_SHIFT,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] sreg;
  logic [BCW-1:0]        bit_cnt;
  logic [BCW-1:0]        ver_cnt;
  logic [WCW-1:0]        wbit_cnt;
  logic [CCW-1:0]        clr_cnt;
  logic [15:0]           load_crc;
  logic [15:0]           ver_crc;
  logic                  config_in_q;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0]           load_crc_next;
  logic [15:0]           ver_crc_next;
  logic [WORD_WIDTH-1:0] sreg_next;

  assign load_crc_next = crc16_step(load_crc, config_in_q);
  assign ver_crc_next  = crc16_step(ver_crc, config_out);
  assign sreg_next     = sreg >> 1;

  // During VERIFY the chain is a closed ring through this block, so contents survive the pass.
  assign config_in = (state == S_VERIFY) ? config_out : config_in_q;

  // NOTE: every register here is assigned with <= so all updates take effect together
  // at the clock edge; blocking assignments would let later lines see half-updated state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state         <= S_IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      ver_cnt       <= '0;
      wbit_cnt      <= '0;
      clr_cnt       <= '0;
      load_crc      <= '0;
      ver_crc       <= '0;
      config_in_q   <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b0;
      word_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      crc_error     <= 1'b0;
      crc_value     <= '0;
    end else if (abort) begin
      state         <= S_IDLE;
      config_in_q   <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b1;
      word_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      crc_error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          config_nreset <= 1'b1;
          if (start) begin
            state         <= S_CLEAR;
            config_nreset <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            crc_error     <= 1'b0;
            load_crc      <= CRC_INIT;
            bit_cnt       <= '0;
            clr_cnt       <= '0;
          end
        end

        S_CLEAR: begin
          if (clr_cnt == LAST_CLR) begin
            state         <= S_FETCH;
            config_nreset <= 1'b1;
            word_ready    <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        S_FETCH: begin
          if (word_valid) begin
            state         <= S_SHIFT;
            word_ready    <= 1'b0;
            sreg          <= word_data;
            config_in_q   <= word_data[0];
            config_enable <= 1'b1;
            wbit_cnt      <= '0;
          end
        end

        // The bit on config_in_q is taken by the chain on this edge.
        S_SHIFT: begin
          load_crc <= load_crc_next;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state       <= S_VERIFY;
            crc_value   <= load_crc_next;
            ver_crc     <= CRC_INIT;
            ver_cnt     <= '0;
            config_in_q <= 1'b0;
          end else if (wbit_cnt == LAST_WBIT) begin
            state         <= S_FETCH;
            config_enable <= 1'b0;
            config_in_q   <= 1'b0;
            word_ready    <= 1'b1;
          end else begin
            sreg        <= sreg_next;
            config_in_q <= sreg_next[0];
            wbit_cnt    <= wbit_cnt + 1'b1;
          end
        end

        S_VERIFY: begin
          ver_crc <= ver_crc_next;
          if (ver_cnt == LAST_BIT) begin
            state         <= S_DONE;
            config_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            crc_error     <= (ver_crc_next != load_crc);
          end else begin
            ver_cnt <= ver_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader: behavioural chain model, bit/CRC
// scoreboard queues filled as words are driven and drained as the DUT shifts.
module tb_config_chain_loader;

  localparam int L  = 36;
  localparam int WW = 16;
  localparam int CC = 4;
  localparam int L2 = 16;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, config_in, config_enable, config_nreset, config_out;
  logic          busy, done, crc_error;
  logic [15:0]   crc_value;

  logic          start2 = 1'b0;
  logic [15:0]   word_data2 = '0;
  logic          word_valid2 = 1'b0;
  logic          word_ready2, config_in2, config_enable2, config_nreset2, config_out2;
  logic          busy2, done2, crc_error2;
  logic [15:0]   crc_value2;

  always #5 clock = ~clock;

  config_chain_loader #(.CHAIN_LENGTH(L), .WORD_WIDTH(WW), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .config_in(config_in), .config_enable(config_enable), .config_nreset(config_nreset),
    .config_out(config_out), .busy(busy), .done(done), .crc_error(crc_error),
    .crc_value(crc_value)
  );

  config_chain_loader #(.CHAIN_LENGTH(L2), .WORD_WIDTH(16), .CLEAR_CYCLES(CC)) dut2 (
    .clock(clock), .nreset(nreset), .start(start2), .abort(1'b0),
    .word_data(word_data2), .word_valid(word_valid2), .word_ready(word_ready2),
    .config_in(config_in2), .config_enable(config_enable2), .config_nreset(config_nreset2),
    .config_out(config_out2), .busy(busy2), .done(done2), .crc_error(crc_error2),
    .crc_value(crc_value2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Chain models: chain[L-1] is the deepest flop, first bit pushed lands there.
  logic [L-1:0]  chain = '0;
  logic [L2-1:0] chain2 = '0;
  int            mcnt = 0;
  logic          flip_en = 1'b0;

  assign config_out  = chain[L-1] ^ (flip_en && (mcnt == L + 10));
  assign config_out2 = chain2[L2-1];

  always @(posedge clock) begin
    if (!config_nreset) begin
      chain <= '0;
      mcnt  <= 0;
    end else if (config_enable) begin
      chain <= {chain[L-2:0], config_in};
      mcnt  <= mcnt + 1;
    end
  end

  always @(posedge clock) begin
    if (!config_nreset2) chain2 <= '0;
    else if (config_enable2) chain2 <= {chain2[L2-2:0], config_in2};
  end

  int hs2 = 0;
  always @(posedge clock) if (word_valid2 && word_ready2) hs2 <= hs2 + 1;

  // Scoreboard
  logic        exp_q[$];
  logic [15:0] crc_q[$];
  logic        err_q[$];
  logic [L-1:0] exp_chain;
  logic [15:0] crc_ref;
  int          pushed;
  int          en_cnt = 0;

  always @(negedge clock) begin
    logic b;
    if (!config_nreset) en_cnt = 0;
    else if (config_enable) begin
      if (en_cnt < L) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'd0, 64'd1);
        else begin
          b = exp_q.pop_front();
          check("chain_bit", {63'd0, config_in}, {63'd0, b});
        end
      end
      en_cnt++;
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_word_ready"},    {63'd0, word_ready},    64'd0);
    check({pfx, "_config_in"},     {63'd0, config_in},     64'd0);
    check({pfx, "_config_enable"}, {63'd0, config_enable}, 64'd0);
    check({pfx, "_config_nreset"}, {63'd0, config_nreset}, 64'd0);
    check({pfx, "_busy"},          {63'd0, busy},          64'd0);
    check({pfx, "_done"},          {63'd0, done},          64'd0);
    check({pfx, "_crc_error"},     {63'd0, crc_error},     64'd0);
    check({pfx, "_crc_value"},     {48'd0, crc_value},     64'd0);
  endtask

  task automatic do_start();
    int n = 0;
    int t = 0;
    exp_q.delete();
    pushed    = 0;
    crc_ref   = 16'hFFFF;
    exp_chain = '0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!word_ready && t < 50) begin
      if (!config_nreset) n++;
      t++;
      @(negedge clock);
    end
    check("clear_len", 64'(n), 64'(CC));
    check("ready_after_clear", {63'd0, word_ready}, 64'd1);
    check("nreset_after_clear", {63'd0, config_nreset}, 64'd1);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int t = 0;
    if (gap > 0) begin
      while (!word_ready && t < 100) begin t++; @(negedge clock); end
      for (int g = 0; g < gap; g++) begin
        check("gap_enable_low", {63'd0, config_enable}, 64'd0);
        start = (g == 1);
        @(negedge clock);
      end
      start = 1'b0;
    end
    for (int i = 0; i < WW; i++) begin
      if (pushed < L) begin
        exp_q.push_back(w[i]);
        exp_chain[L-1-pushed] = w[i];
        crc_ref = crc_step(crc_ref, w[i]);
        pushed++;
      end
    end
    word_data  = w;
    word_valid = 1'b1;
    t = 0;
    while (!word_ready && t < 100) begin t++; @(negedge clock); end
    check("handshake_ready", {63'd0, word_ready}, 64'd1);
    @(negedge clock);
    word_valid = 1'b0;
  endtask

  task automatic load_three(input int gap, input logic exp_err);
    send_word(16'hA5C3, gap);
    send_word(16'h1234, gap);
    send_word(16'h000F, gap);
    crc_q.push_back(crc_ref);
    err_q.push_back(exp_err);
  endtask

  task automatic wait_done(input logic check_chain);
    int t = 0;
    while (!done && t < 500) begin t++; @(negedge clock); end
    check("done", {63'd0, done}, 64'd1);
    check("busy_in_done", {63'd0, busy}, 64'd0);
    check("enable_cycles", 64'(en_cnt), 64'(2 * L));
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    if (crc_q.size() == 0) check("crc_q_underflow", 64'd0, 64'd1);
    else begin
      check("crc_value", {48'd0, crc_value}, {48'd0, crc_q.pop_front()});
      check("crc_error", {63'd0, crc_error}, {63'd0, err_q.pop_front()});
    end
    if (check_chain) check("chain_contents", 64'(chain), 64'(exp_chain));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic ready_seen;
    logic [15:0] c2;

    #12;
    check_reset_outputs("reset");
    @(negedge clock); nreset = 1'b1;
    @(negedge clock); @(negedge clock);
    check("idle_nreset_high", {63'd0, config_nreset}, 64'd1);

    // Back-to-back words
    do_start();
    load_three(0, 1'b0);
    wait_done(1'b1);

    // Gapped words, with a stray start pulse while busy
    do_start();
    load_three(5, 1'b0);
    wait_done(1'b1);

    // Corrupted recirculation
    flip_en = 1'b1;
    do_start();
    load_three(0, 1'b1);
    wait_done(1'b0);
    flip_en = 1'b0;

    // Abort mid-shift, then a clean reload
    do_start();
    send_word(16'hA5C3, 0);
    send_word(16'h1234, 0);
    t = 0;
    while (en_cnt < 20 && t < 100) begin t++; @(negedge clock); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_enable", {63'd0, config_enable}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_nreset", {63'd0, config_nreset}, 64'd1);
    exp_q.delete();
    do_start();
    load_three(0, 1'b0);
    wait_done(1'b1);

    // Asynchronous reset in the middle of VERIFY
    do_start();
    load_three(0, 1'b0);
    t = 0;
    while (en_cnt < L + 5 && t < 200) begin t++; @(negedge clock); end
    check("reached_verify", {63'd0, config_enable}, 64'd1);
    #2 nreset = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete(); crc_q.delete(); err_q.delete();
    @(negedge clock); nreset = 1'b1;

    // Single-word chain on the second instance
    c2 = 16'hFFFF;
    for (int i = 0; i < 16; i++) c2 = crc_step(c2, 1'b1);
    crc_q.push_back(c2);
    err_q.push_back(1'b0);
    @(negedge clock); start2 = 1'b1;
    @(negedge clock); start2 = 1'b0;
    t = 0;
    while (!word_ready2 && t < 50) begin t++; @(negedge clock); end
    check("w2_ready", {63'd0, word_ready2}, 64'd1);
    word_data2  = 16'hFFFF;
    word_valid2 = 1'b1;
    @(negedge clock);
    ready_seen = 1'b0;
    t = 0;
    while (!done2 && t < 200) begin
      if (word_ready2) ready_seen = 1'b1;
      t++;
      @(negedge clock);
    end
    word_valid2 = 1'b0;
    check("w2_done", {63'd0, done2}, 64'd1);
    check("w2_ready_after_hs", {63'd0, ready_seen}, 64'd0);
    check("w2_handshakes", 64'(hs2), 64'd1);
    check("w2_chain", {48'd0, chain2}, 64'h0000_0000_0000_FFFF);
    check("w2_crc_value", {48'd0, crc_value2}, {48'd0, crc_q.pop_front()});
    check("w2_crc_error", {63'd0, crc_error2}, {63'd0, err_q.pop_front()});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Transmit end of the tile configuration shift chain.
- Accepts configuration words from a host over a valid/ready port and serialises them into the chain's config_in/config_enable/config_nreset pins.
- After loading, recirculates the chain through config_out to check the stored contents against a CRC taken during load.
- Sits between the bitstream source and the first tile's config_in; the last tile's config_out returns to this block.

Parameters:
- CHAIN_LENGTH, 36, total flip-flops in the config chain; must be >= 1.
- WORD_WIDTH, 16, host word width; must be >= 1.
- CLEAR_CYCLES, 4, cycles config_nreset is held low at start; must be >= 1.

Ports:
- clock  in  1  system clock; all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load; ignored unless IDLE.
- abort  in  1  returns to IDLE from any state next cycle.
- word_data  in  WORD_WIDTH  host configuration word.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word this cycle.
- config_in  out  1  serial bit to first tile of the chain.
- config_enable  out  1  chain shift enable.
- config_nreset  out  1  chain reset, active-low.
- config_out  in  1  serial bit from last tile of the chain.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE; cleared on next start.
- crc_error  out  1  verify mismatch; valid when done=1.
- crc_value  out  16  CRC accumulated during LOAD.

Behaviour:
- Reset (nreset low, async): state IDLE; config_in=0, config_enable=0, config_nreset=0, word_ready=0, busy=0, done=0, crc_error=0, crc_value=0.
- config_nreset=1 in all states except CLEAR and reset.
- Chain contract: the chain shifts config_in in on each rising edge with config_enable=1. The first bit pushed ends at the deepest position and is the first bit seen on config_out.
- States:
  - IDLE: on start -> CLEAR. Clear done and crc_error, set crc to 0xFFFF, bit counter to 0.
  - CLEAR: config_nreset=0 for exactly CLEAR_CYCLES cycles -> FETCH.
  - FETCH: word_ready=1, config_enable=0. On word_valid&word_ready, latch word into the shift register -> SHIFT.
  - SHIFT: one bit per cycle, LSB first. config_in=sreg[0] and config_enable=1 are registered outputs, so chain bit n = word (n / WORD_WIDTH), bit (n mod WORD_WIDTH). Each shifted bit updates the CRC.
    - After WORD_WIDTH bits -> FETCH.
    - When the total bit count reaches CHAIN_LENGTH -> VERIFY, even mid-word. Remaining bits of the final word are discarded and no further words are accepted.
  - VERIFY: config_enable=1 for exactly CHAIN_LENGTH cycles. config_in = config_out (combinational loopback), so chain contents are unchanged afterwards. config_out is sampled at each enabling edge into a second CRC -> DONE.
  - DONE: done=1. crc_error = (verify CRC != load CRC). On start -> CLEAR.
- CRC-16-CCITT, bit-serial: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0). Init 0xFFFF.
- crc_value is updated at the end of LOAD and held until the next start.
- Word gaps: while in FETCH with word_valid=0, config_enable=0 and the chain holds; bit count is preserved.
- abort: next cycle IDLE, config_enable=0, config_nreset=1, done=0. Chain contents are undefined and host must restart. abort has priority over start and word handshakes in the same cycle.
- start while busy: ignored.
- Bit counter width: clog2(CHAIN_LENGTH+1); no wrap.
- Total config_enable-high cycles per run: exactly 2*CHAIN_LENGTH.

Test Plan:
- Defaults, words 0xA5C3, 0x1234, 0x000F, no gaps: config_enable high for 36 cycles in LOAD. The bit stream equals the LSB-first concatenation truncated to 36 bits; only the low 4 bits of word 3 are used. A behavioural chain model holds that pattern; done=1, crc_error=0; crc_value matches the reference CRC of the 36 bits.
- Same words with 5-cycle word_valid gaps between words: identical chain contents and crc_value; config_enable is low during gaps.
- Chain model forced to flip bit 10 during VERIFY: done=1, crc_error=1.
- abort asserted mid-SHIFT at bit 20: next cycle busy=0, config_enable=0, done=0. A following start reloads cleanly and ends with crc_error=0.
- CLEAR timing: after start, config_nreset is low for exactly 4 cycles before word_ready rises. Also assert nreset mid-VERIFY: all outputs take their reset values immediately (async).
- CHAIN_LENGTH=16, WORD_WIDTH=16, single word 0xFFFF: exactly one handshake; word_ready stays 0 after the handshake; done=1, crc_error=0.
